stopwatch_core: RTL and testbench

//   Timekeeping core of the lab9 stopwatch. It counts elapsed time as four BCD digits, SS.hh (00.00 to 59.99).

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/stopwatch_if.sv | 22 ++
 rtl/claadder_gate.sv | 27 ++
 rtl/stopwatch_bcd_digit_stage.sv | 40 ++++
 rtl/stopwatch_core.sv | 105 ++++++++++
 tb/tb_stopwatch_core.sv | 155 +++++++++++++++
 6 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding and BCD digit wrap limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] LIM_DEC  = 4'd10;
    localparam logic [3:0] LIM_SEXT = 4'd6;

endpackage

// File: rtl/stopwatch_if.sv
// Button pulses in, display digits and status out. The lap/lap_active pair exists only with STOPWATCH_LAP_EN.
interface stopwatch_if;
    logic        start_stop;
    logic        clear;
    logic [15:0] bcd;
    logic        running;
    logic        rollover;
`ifdef STOPWATCH_LAP_EN
    logic        lap;
    logic        lap_active;

    modport master (output start_stop, clear, lap,
                    input  bcd, running, rollover, lap_active);
    modport slave  (input  start_stop, clear, lap,
                    output bcd, running, rollover, lap_active);
`else
    modport master (output start_stop, clear,
                    input  bcd, running, rollover);
    modport slave  (input  start_stop, clear,
                    output bcd, running, rollover);
`endif
endinterface

// File: rtl/claadder_gate.sv
// 4-bit carry-lookahead adder built from gate-level generate/propagate terms.
// Latency: combinational.
// Backpressure: none.
module claadder_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/stopwatch_bcd_digit_stage.sv
// One BCD digit of the chain: adder increment, wrap at LIMIT, digit register.
// Latency: digit updates on the edge where cin is high; carry_out is combinational.
// Backpressure: none; clear overrides any increment.
module bcd_digit_stage
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] LIMIT = LIM_DEC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cin,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       carry_out
);
    logic [3:0] sum;
    logic       cout;
    logic       wrap;

    claadder_gate u_add (
        .a    (digit),
        .b    (4'h0),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // cout cannot rise for a valid BCD digit; folding it in keeps the wrap safe.
    assign wrap      = (sum == LIMIT) | cout;
    assign carry_out = cin & wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digit <= 4'd0;
        else if (clear)
            digit <= 4'd0;
        else if (cin)
            digit <= wrap ? 4'd0 : sum;
    end
endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: SS.hh BCD count, run/pause/clear FSM, optional lap freeze (STOPWATCH_LAP_EN).
// Latency: bcd moves on the tick edge; running follows the state register; rollover is a 1-cycle pulse after the wrap edge.
// Backpressure: none; button pulses are consumed in the cycle they arrive, clear wins over start_stop.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    stopwatch_if.slave  sw
);
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] prescaler;
    logic             tick;
    logic [4:0]       carry;
    logic [15:0]      live;
    logic             rollover_q;

    assign tick = (state == ST_RUN) && (prescaler == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (sw.clear) begin
            state_nx = ST_IDLE;
        end else if (sw.start_stop) begin
            case (state)
                ST_IDLE:  state_nx = ST_RUN;
                ST_RUN:   state_nx = ST_PAUSE;
                ST_PAUSE: state_nx = ST_RUN;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Held in PAUSE so a resume finishes the partial tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prescaler <= '0;
        else if (sw.clear || state == ST_IDLE)
            prescaler <= '0;
        else if (state == ST_RUN)
            prescaler <= tick ? '0 : prescaler + 1'b1;
    end

    assign carry[0] = tick;

    bcd_digit_stage #(.LIMIT(LIM_DEC)) u_hund (
        .clk(clk), .reset(reset), .cin(carry[0]), .clear(sw.clear),
        .digit(live[3:0]), .carry_out(carry[1]));

    bcd_digit_stage #(.LIMIT(LIM_DEC)) u_tenth (
        .clk(clk), .reset(reset), .cin(carry[1]), .clear(sw.clear),
        .digit(live[7:4]), .carry_out(carry[2]));

    bcd_digit_stage #(.LIMIT(LIM_DEC)) u_sec_units (
        .clk(clk), .reset(reset), .cin(carry[2]), .clear(sw.clear),
        .digit(live[11:8]), .carry_out(carry[3]));

    bcd_digit_stage #(.LIMIT(LIM_SEXT)) u_sec_tens (
        .clk(clk), .reset(reset), .cin(carry[3]), .clear(sw.clear),
        .digit(live[15:12]), .carry_out(carry[4]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rollover_q <= 1'b0;
        else
            rollover_q <= carry[4] & ~sw.clear;
    end

    assign sw.running  = (state == ST_RUN);
    assign sw.rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_q;
    logic [15:0] lap_bcd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q   <= 1'b0;
            lap_bcd <= 16'h0000;
        end else if (sw.clear) begin
            lap_q   <= 1'b0;
        end else if (sw.lap && state != ST_IDLE) begin
            if (!lap_q)
                lap_bcd <= live;
            lap_q <= ~lap_q;
        end
    end

    assign sw.lap_active = lap_q;
    assign sw.bcd        = lap_q ? lap_bcd : live;
`else
    assign sw.bcd = live;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV = 4: reset, pause/resume, carry chain, wrap, clear, async reset, lap.
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stopwatch_if sw();

    stopwatch_core #(.TICK_DIV(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_ss();
        sw.start_stop = 1'b1;
        step(1);
        sw.start_stop = 1'b0;
    endtask

    task automatic press_clear();
        sw.clear = 1'b1;
        step(1);
        sw.clear = 1'b0;
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic press_lap();
        sw.lap = 1'b1;
        step(1);
        sw.lap = 1'b0;
    endtask
`endif

    initial begin
        reset         = 1'b1;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw.lap        = 1'b0;
`endif

        // 1: reset values, then 40 cycles of running = 10 ticks
        step(2);
        check("rst_bcd", sw.bcd, 16'h0000);
        check("rst_running", {15'd0, sw.running}, 16'd0);
        check("rst_rollover", {15'd0, sw.rollover}, 16'd0);
        reset = 1'b0;
        step(1);
        press_ss();
        step(40);
        check("run40_bcd", sw.bcd, 16'h0010);
        check("run40_running", {15'd0, sw.running}, 16'd1);

        // 2: pause two cycles into a tick, hold, resume
        step(1);
        press_ss();
        check("pause_running", {15'd0, sw.running}, 16'd0);
        step(20);
        check("pause_hold_bcd", sw.bcd, 16'h0010);
        press_ss();
        step(1);
        check("resume_r1_bcd", sw.bcd, 16'h0010);
        check("resume_running", {15'd0, sw.running}, 16'd1);
        step(1);
        check("resume_r2_bcd", sw.bcd, 16'h0011);

        // 3: carry chain and wrap
        press_clear();
        check("clr_bcd", sw.bcd, 16'h0000);
        check("clr_running", {15'd0, sw.running}, 16'd0);
        press_ss();
        step(3996);
        check("cnt_0999", sw.bcd, 16'h0999);
        step(4);
        check("cnt_1000", sw.bcd, 16'h1000);
        step(19996);
        check("cnt_5999", sw.bcd, 16'h5999);
        check("pre_wrap_rollover", {15'd0, sw.rollover}, 16'd0);
        step(4);
        check("wrap_bcd", sw.bcd, 16'h0000);
        check("wrap_rollover", {15'd0, sw.rollover}, 16'd1);
        check("wrap_running", {15'd0, sw.running}, 16'd1);
        step(1);
        check("wrap_rollover_drop", {15'd0, sw.rollover}, 16'd0);

        // 4: clear and start_stop together while running
        step(7);
        check("after_wrap_bcd", sw.bcd, 16'h0002);
        sw.clear      = 1'b1;
        sw.start_stop = 1'b1;
        step(1);
        sw.clear      = 1'b0;
        sw.start_stop = 1'b0;
        check("clr_ss_bcd", sw.bcd, 16'h0000);
        check("clr_ss_running", {15'd0, sw.running}, 16'd0);
        step(8);
        check("idle_hold_bcd", sw.bcd, 16'h0000);

        // 5: asynchronous reset at 12.34
        press_ss();
        step(4936);
        check("cnt_1234", sw.bcd, 16'h1234);
        reset = 1'b1;
        #1;
        check("async_rst_bcd", sw.bcd, 16'h0000);
        check("async_rst_running", {15'd0, sw.running}, 16'd0);
        check("async_rst_rollover", {15'd0, sw.rollover}, 16'd0);
        step(1);
        reset = 1'b0;
        step(8);
        check("post_rst_idle_bcd", sw.bcd, 16'h0000);
        press_ss();
        step(8);
        check("post_rst_restart", sw.bcd, 16'h0002);

`ifdef STOPWATCH_LAP_EN
        // 6: lap freeze and release
        press_clear();
        press_lap();
        check("lap_idle_ignored", {15'd0, sw.lap_active}, 16'd0);
        press_ss();
        step(1284);
        check("lap_pre_bcd", sw.bcd, 16'h0321);
        press_lap();
        check("lap_active_on", {15'd0, sw.lap_active}, 16'd1);
        step(100);
        check("lap_frozen_bcd", sw.bcd, 16'h0321);
        press_lap();
        check("lap_release_bcd", sw.bcd, 16'h0346);
        check("lap_active_off", {15'd0, sw.lap_active}, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
